// File: rtl/rob_retire_if.sv
`default_nettype none
// ============================================================================
// Module  : rob_retire_if
// Brief   : Dispatch/complete/retire/free-pool bundle for the reorder buffer.
// Revision: 1.0 - initial release
// ============================================================================
interface rob_retire_if #(
    parameter int DEPTH  = 16,
    parameter int PREG_W = 6,
    parameter int XLEN   = 32,
    parameter int IDX_W  = $clog2(DEPTH)
);
    logic              alloc_valid;
    logic              alloc_ready;
    logic [4:0]        alloc_rd;
    logic              alloc_wen;
    logic [PREG_W-1:0] alloc_pd;
    logic [PREG_W-1:0] alloc_old_pd;
    logic [IDX_W-1:0]  alloc_idx;
    logic              cmpl_valid;
    logic [IDX_W-1:0]  cmpl_idx;
    logic [XLEN-1:0]   cmpl_value;
    logic              ret_valid;
    logic              ret_wen;
    logic [4:0]        ret_rd;
    logic [PREG_W-1:0] ret_pd;
    logic [XLEN-1:0]   ret_value;
    logic              free_valid;
    logic [PREG_W-1:0] free_preg;
    logic              free_ready;
    logic [IDX_W:0]    occupancy;

    modport slave (
        input  alloc_valid, alloc_rd, alloc_wen, alloc_pd, alloc_old_pd,
        input  cmpl_valid, cmpl_idx, cmpl_value, free_ready,
        output alloc_ready, alloc_idx, ret_valid, ret_wen, ret_rd, ret_pd,
        output ret_value, free_valid, free_preg, occupancy
    );

    modport master (
        output alloc_valid, alloc_rd, alloc_wen, alloc_pd, alloc_old_pd,
        output cmpl_valid, cmpl_idx, cmpl_value, free_ready,
        input  alloc_ready, alloc_idx, ret_valid, ret_wen, ret_rd, ret_pd,
        input  ret_value, free_valid, free_preg, occupancy
    );
endinterface
`default_nettype wire

// File: rtl/rob_retire.sv
`default_nettype none
// ============================================================================
// Module  : rob_retire
// Brief   : In-order ROB; retires the oldest completed entry and frees its
//           stale physical register. ROB_PERF_EN adds retire/stall counters.
// Revision: 1.0 - initial release
// ============================================================================
module rob_retire #(
    parameter int DEPTH  = 16,
    parameter int PREG_W = 6,
    parameter int XLEN   = 32
) (
    input  wire         clk,
    input  wire         reset,
`ifdef ROB_PERF_EN
    output logic [31:0] perf_retired,
    output logic [31:0] perf_stall,
`endif
    rob_retire_if.slave bus
);
    localparam int             IDX_W   = $clog2(DEPTH);
    localparam logic [IDX_W:0] PTR_ONE = {{IDX_W{1'b0}}, 1'b1};

    logic [IDX_W:0]                head_q, head_d, tail_q, tail_d;
    logic [DEPTH-1:0]              valid_q, valid_d;
    logic [DEPTH-1:0]              complete_q, complete_d;
    logic [DEPTH-1:0]              wen_q, wen_d;
    logic [DEPTH-1:0][4:0]         rd_q, rd_d;
    logic [DEPTH-1:0][PREG_W-1:0]  pd_q, pd_d;
    logic [DEPTH-1:0][PREG_W-1:0]  old_pd_q, old_pd_d;
    logic [DEPTH-1:0][XLEN-1:0]    value_q, value_d;

    logic                          ret_valid_q, ret_valid_d;
    logic                          ret_wen_q, ret_wen_d;
    logic [4:0]                    ret_rd_q, ret_rd_d;
    logic [PREG_W-1:0]             ret_pd_q, ret_pd_d;
    logic [XLEN-1:0]               ret_value_q, ret_value_d;
    logic                          free_valid_q, free_valid_d;
    logic [PREG_W-1:0]             free_preg_q, free_preg_d;

    logic [IDX_W-1:0]              head_idx, tail_idx;
    logic                          full, alloc_fire, retire;

    always_comb begin
        head_idx   = head_q[IDX_W-1:0];
        tail_idx   = tail_q[IDX_W-1:0];
        full       = (head_idx == tail_idx) && (head_q[IDX_W] != tail_q[IDX_W]);
        alloc_fire = bus.alloc_valid && !full;
        retire     = valid_q[head_idx] && complete_q[head_idx] &&
                     (!wen_q[head_idx] || bus.free_ready);
    end

    always_comb begin
        head_d       = head_q;
        tail_d       = tail_q;
        valid_d      = valid_q;
        complete_d   = complete_q;
        wen_d        = wen_q;
        rd_d         = rd_q;
        pd_d         = pd_q;
        old_pd_d     = old_pd_q;
        value_d      = value_q;
        ret_valid_d  = 1'b0;
        ret_wen_d    = ret_wen_q;
        ret_rd_d     = ret_rd_q;
        ret_pd_d     = ret_pd_q;
        ret_value_d  = ret_value_q;
        free_valid_d = 1'b0;
        free_preg_d  = free_preg_q;

        // Completion sees registered valid, so a same-cycle alloc to the tail is ignored
        if (bus.cmpl_valid && valid_q[bus.cmpl_idx] && !complete_q[bus.cmpl_idx]) begin
            complete_d[bus.cmpl_idx] = 1'b1;
            value_d[bus.cmpl_idx]    = bus.cmpl_value;
        end

        if (retire) begin
            valid_d[head_idx]    = 1'b0;
            complete_d[head_idx] = 1'b0;
            head_d               = head_q + PTR_ONE;
            ret_valid_d          = 1'b1;
            ret_wen_d            = wen_q[head_idx];
            ret_rd_d             = rd_q[head_idx];
            ret_pd_d             = pd_q[head_idx];
            ret_value_d          = value_q[head_idx];
            free_valid_d         = wen_q[head_idx];
            if (wen_q[head_idx]) begin
                free_preg_d = old_pd_q[head_idx];
            end
        end

        if (alloc_fire) begin
            valid_d[tail_idx]    = 1'b1;
            complete_d[tail_idx] = 1'b0;
            wen_d[tail_idx]      = bus.alloc_wen && (bus.alloc_rd != 5'd0);
            rd_d[tail_idx]       = bus.alloc_rd;
            pd_d[tail_idx]       = bus.alloc_pd;
            old_pd_d[tail_idx]   = bus.alloc_old_pd;
            tail_d               = tail_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q       <= '0;
            tail_q       <= '0;
            valid_q      <= '0;
            complete_q   <= '0;
            wen_q        <= '0;
            rd_q         <= '0;
            pd_q         <= '0;
            old_pd_q     <= '0;
            value_q      <= '0;
            ret_valid_q  <= 1'b0;
            ret_wen_q    <= 1'b0;
            ret_rd_q     <= '0;
            ret_pd_q     <= '0;
            ret_value_q  <= '0;
            free_valid_q <= 1'b0;
            free_preg_q  <= '0;
        end else begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            valid_q      <= valid_d;
            complete_q   <= complete_d;
            wen_q        <= wen_d;
            rd_q         <= rd_d;
            pd_q         <= pd_d;
            old_pd_q     <= old_pd_d;
            value_q      <= value_d;
            ret_valid_q  <= ret_valid_d;
            ret_wen_q    <= ret_wen_d;
            ret_rd_q     <= ret_rd_d;
            ret_pd_q     <= ret_pd_d;
            ret_value_q  <= ret_value_d;
            free_valid_q <= free_valid_d;
            free_preg_q  <= free_preg_d;
        end
    end

`ifdef ROB_PERF_EN
    logic [31:0] perf_retired_q, perf_retired_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    always_comb begin
        perf_retired_d = perf_retired_q;
        perf_stall_d   = perf_stall_q;
        if (retire) begin
            perf_retired_d = perf_retired_q + 32'd1;
        end else if (valid_q[head_idx]) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_retired_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            perf_retired_q <= perf_retired_d;
            perf_stall_q   <= perf_stall_d;
        end
    end

    assign perf_retired = perf_retired_q;
    assign perf_stall   = perf_stall_q;
`endif

    // Pointer-derived outputs come from registered state only
    assign bus.alloc_ready = !full;
    assign bus.alloc_idx   = tail_idx;
    assign bus.occupancy   = tail_q - head_q;
    assign bus.ret_valid   = ret_valid_q;
    assign bus.ret_wen     = ret_wen_q;
    assign bus.ret_rd      = ret_rd_q;
    assign bus.ret_pd      = ret_pd_q;
    assign bus.ret_value   = ret_value_q;
    assign bus.free_valid  = free_valid_q;
    assign bus.free_preg   = free_preg_q;

endmodule
`default_nettype wire

// File: tb/tb_rob_retire.sv
`default_nettype none
// ============================================================================
// Module  : tb_rob_retire
// Brief   : Self-checking bench for rob_retire: vector table, directed corner
//           sequences and random traffic against a queue-based reference.
// Revision: 1.0 - initial release
// ============================================================================
module tb_rob_retire;
    localparam int DEPTH  = 16;
    localparam int PREG_W = 6;
    localparam int XLEN   = 32;
    localparam int IDX_W  = 4;

    logic clk = 1'b0;
    logic reset;
`ifdef ROB_PERF_EN
    logic [31:0] perf_retired, perf_stall;
`endif

    rob_retire_if #(.DEPTH(DEPTH), .PREG_W(PREG_W), .XLEN(XLEN)) bus ();

    rob_retire #(.DEPTH(DEPTH), .PREG_W(PREG_W), .XLEN(XLEN)) dut (
        .clk          (clk),
        .reset        (reset),
`ifdef ROB_PERF_EN
        .perf_retired (perf_retired),
        .perf_stall   (perf_stall),
`endif
        .bus          (bus)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [4:0]        rd;
        bit                wen;
        logic [PREG_W-1:0] pd;
        logic [PREG_W-1:0] old;
        logic [XLEN-1:0]   val;
        bit                done;
    } ent_t;

    ent_t mq[$];
    int   tcnt, hcnt;
    bit                m_rv, m_wen, m_fv;
    logic [4:0]        m_rd;
    logic [PREG_W-1:0] m_pd, m_fp;
    logic [XLEN-1:0]   m_val;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        bus.alloc_valid = 1'b0;
        bus.cmpl_valid  = 1'b0;
    endtask

    task automatic set_alloc(input logic [4:0] rd, input bit wen,
                             input logic [PREG_W-1:0] pd, input logic [PREG_W-1:0] old);
        bus.alloc_valid  = 1'b1;
        bus.alloc_rd     = rd;
        bus.alloc_wen    = wen;
        bus.alloc_pd     = pd;
        bus.alloc_old_pd = old;
    endtask

    task automatic set_cmpl(input logic [IDX_W-1:0] idx, input logic [XLEN-1:0] v);
        bus.cmpl_valid = 1'b1;
        bus.cmpl_idx   = idx;
        bus.cmpl_value = v;
    endtask

    // Advance one edge: predict from the instruction-queue model, then compare.
    task automatic cycle();
        ent_t e;
        int   pos;
        bit   acc, ret_now, was_reset;
        was_reset = reset;
        if (reset) begin
            mq.delete();
            tcnt = 0; hcnt = 0;
            m_rv = 0; m_wen = 0; m_fv = 0; m_rd = '0; m_pd = '0; m_fp = '0; m_val = '0;
        end else begin
            acc     = bus.alloc_valid && (mq.size() < DEPTH);
            ret_now = (mq.size() > 0) && mq[0].done && (!mq[0].wen || bus.free_ready);
            if (bus.cmpl_valid) begin
                pos = (int'(bus.cmpl_idx) - (hcnt % DEPTH) + DEPTH) % DEPTH;
                if (pos < mq.size() && !mq[pos].done) begin
                    e = mq[pos]; e.done = 1; e.val = bus.cmpl_value; mq[pos] = e;
                end
            end
            m_rv = ret_now;
            m_fv = 0;
            if (ret_now) begin
                e = mq.pop_front();
                hcnt++;
                m_wen = e.wen; m_rd = e.rd; m_pd = e.pd; m_val = e.val; m_fv = e.wen;
                if (e.wen) m_fp = e.old;
            end
            if (acc) begin
                e.rd = bus.alloc_rd; e.wen = bus.alloc_wen && (bus.alloc_rd != 5'd0);
                e.pd = bus.alloc_pd; e.old = bus.alloc_old_pd; e.val = '0; e.done = 0;
                mq.push_back(e);
                tcnt++;
            end
        end
        @(posedge clk);
        #1;
        chk("ret_valid", bus.ret_valid, m_rv);
        chk("free_valid", bus.free_valid, m_fv);
        if (m_rv || was_reset) begin
            chk("ret_wen", bus.ret_wen, m_wen);
            chk("ret_rd", bus.ret_rd, m_rd);
            chk("ret_pd", bus.ret_pd, m_pd);
            chk("ret_value", bus.ret_value, m_val);
        end
        if (m_fv || was_reset) chk("free_preg", bus.free_preg, m_fp);
        chk("occupancy", bus.occupancy, mq.size());
        chk("alloc_ready", bus.alloc_ready, mq.size() < DEPTH);
        chk("alloc_idx", bus.alloc_idx, tcnt % DEPTH);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
    endtask

    typedef struct {
        bit                av;
        logic [4:0]        rd;
        bit                wen;
        logic [PREG_W-1:0] pd;
        logic [PREG_W-1:0] old;
        bit                cv;
        logic [IDX_W-1:0]  ci;
        logic [XLEN-1:0]   cval;
        bit                fr;
        bit                e_rv;
        bit                e_wen;
        logic [4:0]        e_rd;
        logic [PREG_W-1:0] e_pd;
        logic [XLEN-1:0]   e_val;
        bit                e_fv;
        logic [PREG_W-1:0] e_fp;
        int                e_occ;
    } vec_t;

    vec_t vt[8];

    initial begin
        //          av rd wen pd old cv ci cval           fr | rv wen rd pd val          fv fp occ
        vt[0] = '{1, 5, 1, 33, 5,  0, 0, 32'h0,          1,  0, 0, 0, 0,  32'h0,        0, 0, 1};
        vt[1] = '{0, 0, 0, 0,  0,  1, 0, 32'h0000_00AA,  1,  0, 0, 0, 0,  32'h0,        0, 0, 1};
        vt[2] = '{0, 0, 0, 0,  0,  0, 0, 32'h0,          1,  1, 1, 5, 33, 32'h0000_00AA, 1, 5, 0};
        vt[3] = '{0, 0, 0, 0,  0,  1, 7, 32'h55,         1,  0, 0, 0, 0,  32'h0,        0, 0, 0};
        vt[4] = '{1, 0, 1, 40, 41, 0, 0, 32'h0,          1,  0, 0, 0, 0,  32'h0,        0, 0, 1};
        vt[5] = '{0, 0, 0, 0,  0,  1, 1, 32'h1234,       1,  0, 0, 0, 0,  32'h0,        0, 0, 1};
        vt[6] = '{0, 0, 0, 0,  0,  0, 0, 32'h0,          0,  1, 0, 0, 40, 32'h1234,     0, 0, 0};
        vt[7] = '{0, 0, 0, 0,  0,  0, 0, 32'h0,          1,  0, 0, 0, 0,  32'h0,        0, 0, 0};

        reset = 1'b1;
        bus.alloc_valid = 0; bus.alloc_rd = '0; bus.alloc_wen = 0;
        bus.alloc_pd = '0; bus.alloc_old_pd = '0;
        bus.cmpl_valid = 0; bus.cmpl_idx = '0; bus.cmpl_value = '0;
        bus.free_ready = 1'b1;
        do_reset();
        chk("reset_alloc_ready", bus.alloc_ready, 1'b1);

        // Vector table: basic retire, empty-slot completion, rd=0 entry
        for (int i = 0; i < 8; i++) begin
            bus.alloc_valid = vt[i].av;  bus.alloc_rd = vt[i].rd; bus.alloc_wen = vt[i].wen;
            bus.alloc_pd = vt[i].pd;     bus.alloc_old_pd = vt[i].old;
            bus.cmpl_valid = vt[i].cv;   bus.cmpl_idx = vt[i].ci; bus.cmpl_value = vt[i].cval;
            bus.free_ready = vt[i].fr;
            cycle();
            chk("vec_ret_valid", bus.ret_valid, vt[i].e_rv);
            chk("vec_free_valid", bus.free_valid, vt[i].e_fv);
            chk("vec_occupancy", bus.occupancy, vt[i].e_occ);
            if (vt[i].e_rv) begin
                chk("vec_ret_wen", bus.ret_wen, vt[i].e_wen);
                chk("vec_ret_rd", bus.ret_rd, vt[i].e_rd);
                chk("vec_ret_pd", bus.ret_pd, vt[i].e_pd);
                chk("vec_ret_value", bus.ret_value, vt[i].e_val);
            end
            if (vt[i].e_fv) chk("vec_free_preg", bus.free_preg, vt[i].e_fp);
        end
        idle();
        bus.free_ready = 1'b1;

        // Out-of-order completion, in-order retirement
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_alloc(5'(i + 1), 1, PREG_W'(10 + i), PREG_W'(20 + i));
            cycle();
        end
        idle();
        set_cmpl(2, 32'h222); cycle(); chk("ooo_no_ret2", bus.ret_valid, 1'b0);
        set_cmpl(1, 32'h111); cycle(); chk("ooo_no_ret1", bus.ret_valid, 1'b0);
        set_cmpl(0, 32'h100); cycle(); chk("ooo_no_ret0", bus.ret_valid, 1'b0);
        idle();
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("ooo_ret_valid", bus.ret_valid, 1'b1);
            chk("ooo_ret_pd", bus.ret_pd, 10 + i);
        end
        cycle();

        // Fill to DEPTH, reopen, then allocate across the wrap
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            set_alloc(5'(i + 1), 1, PREG_W'(i), PREG_W'(i + 16));
            cycle();
        end
        chk("full_alloc_ready", bus.alloc_ready, 1'b0);
        chk("full_occupancy", bus.occupancy, 16);
        chk("full_alloc_idx", bus.alloc_idx, 0);
        set_cmpl(0, 32'hF00);
        cycle();
        chk("full_still_blocked", bus.alloc_ready, 1'b0);
        idle();
        cycle();
        chk("reopen_alloc_ready", bus.alloc_ready, 1'b1);
        for (int i = 1; i < 20; i++) begin
            set_alloc(5'(i), 1, PREG_W'(i + 32), PREG_W'(i));
            set_cmpl(IDX_W'(i), 32'(i * 3));
            cycle();
        end
        idle();
        for (int i = 0; i < 40; i++) begin
            set_cmpl(IDX_W'(i), 32'(i));
            cycle();
        end
        idle();
        cycle();
        chk("drain_occupancy", bus.occupancy, 0);

        // Free-pool backpressure, and an SW entry retiring through it
        do_reset();
        set_alloc(3, 1, 20, 7); cycle();
        idle();
        set_cmpl(0, 32'hBEEF); cycle();
        idle();
        bus.free_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("bp_stall", bus.ret_valid, 1'b0);
        end
        bus.free_ready = 1'b1;
        cycle();
        chk("bp_release", bus.ret_valid, 1'b1);
        chk("bp_free_preg", bus.free_preg, 7);
        set_alloc(4, 0, 21, 8); cycle();
        idle();
        set_cmpl(1, 32'h5A5A); cycle();
        idle();
        bus.free_ready = 1'b0;
        cycle();
        chk("sw_ret_valid", bus.ret_valid, 1'b1);
        chk("sw_ret_wen", bus.ret_wen, 1'b0);
        chk("sw_free_valid", bus.free_valid, 1'b0);
        bus.free_ready = 1'b1;

        // Reset with five entries in flight, two of them complete
        for (int i = 0; i < 5; i++) begin
            set_alloc(5'(i + 1), 1, PREG_W'(i), PREG_W'(i + 8));
            cycle();
        end
        idle();
        set_cmpl(2, 1); cycle();
        set_cmpl(3, 2); cycle();
        set_cmpl(4, 3);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        idle();
        chk("rst_occupancy", bus.occupancy, 0);
        chk("rst_ret_valid", bus.ret_valid, 1'b0);
        cycle();
        chk("rst_no_stale", bus.ret_valid, 1'b0);

        // Random traffic against the reference model
        for (int i = 0; i < 3000; i++) begin
            bus.alloc_valid  = ($urandom_range(0, 99) < 55);
            bus.alloc_rd     = 5'($urandom_range(0, 31));
            bus.alloc_wen    = 1'($urandom_range(0, 1));
            bus.alloc_pd     = PREG_W'($urandom);
            bus.alloc_old_pd = PREG_W'($urandom);
            bus.cmpl_valid   = ($urandom_range(0, 99) < 60);
            bus.cmpl_idx     = IDX_W'($urandom_range(0, DEPTH - 1));
            bus.cmpl_value   = $urandom;
            bus.free_ready   = ($urandom_range(0, 99) < 70);
            reset            = ($urandom_range(0, 599) == 0);
            cycle();
        end
        reset = 1'b0;
        idle();
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end
endmodule
`default_nettype wire
